// File: rtl/DPE_params.sv
// DPE_params: shared DPE datapath parameters, element/vector types and packer FSM states
package DPE_params;
    localparam int INPUT_VEC_LEN = 8;
    localparam int WIDTH         = 16;
    localparam int LANE_IDX_W    = $clog2(INPUT_VEC_LEN);
    localparam int CNT_W         = $clog2(INPUT_VEC_LEN + 1);
    typedef logic [WIDTH-1:0] elem_t;
    typedef elem_t [INPUT_VEC_LEN-1:0] vec_t;
    typedef enum logic {PK_FILL, PK_HOLD} pk_state_t;
endpackage

// File: rtl/dpe_vec_packer.sv
// dpe_vec_packer: packs a scalar element stream into zero-padded vectors for the DPE vector adder
module dpe_vec_packer #(
    parameter int INPUT_VEC_LEN = DPE_params::INPUT_VEC_LEN,
    parameter int WIDTH         = DPE_params::WIDTH,
    parameter int LANE_IDX_W    = $clog2(INPUT_VEC_LEN),
    parameter int CNT_W         = $clog2(INPUT_VEC_LEN + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  elem_valid,
    output logic                                  elem_ready,
    input  logic [WIDTH-1:0]                      elem_data,
    input  logic                                  elem_last,
    output logic                                  vec_valid,
    input  logic                                  vec_ready,
    output logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]   vec_data,
    output logic [CNT_W-1:0]                      vec_count
);
    import DPE_params::*;

    pk_state_t                           state;
    logic [LANE_IDX_W-1:0]               idx;
    logic [INPUT_VEC_LEN-1:0][WIDTH-1:0] lanes;
    logic [INPUT_VEC_LEN-1:0][WIDTH-1:0] merged;
    logic [CNT_W-1:0]                    pend;
    logic [CNT_W-1:0]                    fill_cnt;
    logic                                accept;
    logic                                completing;
    logic                                slot_free;

    assign elem_ready = rst_n && state == PK_FILL;
    assign accept     = elem_valid && elem_ready;
    assign completing = idx == LANE_IDX_W'(INPUT_VEC_LEN - 1) || elem_last;
    assign slot_free  = !vec_valid || vec_ready;
    assign fill_cnt   = CNT_W'(idx) + CNT_W'(1);

    // Lanes above idx are always zero, so the merged view doubles as the zero-padded vector
    for (genvar i = 0; i < INPUT_VEC_LEN; i++) begin : g_lane
        assign merged[i] = (accept && idx == LANE_IDX_W'(i)) ? elem_data : lanes[i];
    end

    // Fill buffer, HOLD overflow slot and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PK_FILL;
            idx       <= '0;
            lanes     <= '0;
            pend      <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_count <= '0;
        end else begin
            if (vec_valid && vec_ready)
                vec_valid <= 1'b0;
            if (accept) begin
                if (completing && slot_free) begin
                    vec_data  <= merged;
                    vec_count <= fill_cnt;
                    vec_valid <= 1'b1;
                    idx       <= '0;
                    lanes     <= '0;
                end else if (completing) begin
                    lanes <= merged;
                    pend  <= fill_cnt;
                    state <= PK_HOLD;
                end else begin
                    lanes <= merged;
                    idx   <= idx + LANE_IDX_W'(1);
                end
            end
            if (state == PK_HOLD && slot_free) begin
                vec_data  <= lanes;
                vec_count <= pend;
                vec_valid <= 1'b1;
                lanes     <= '0;
                idx       <= '0;
                state     <= PK_FILL;
            end
        end
    end
endmodule
